// File: rtl/first_row_enemy_ctrl.sv
// first_row_enemy_ctrl
//   Sequential controller for a single first-row enemy. It holds the enemy's
//   registered position, alive flag and 2-bit movement phase, and feeds them
//   to the combinational row-move stage. On each movement step it captures
//   that stage's next-position result, clamped to [X_MIN, X_MAX]. It also runs
//   the hit -> dying -> dead lifecycle and handles restart.
//
//   Optional build macro: FIRST_ROW_ENEMY_RESPAWN_EN
//     defined   : DEAD counts RESPAWN_TICKS frame ticks, then the enemy re-enters
//                 ALIVE with the same initialisation as i_Start.
//     undefined : no respawn counter is built; DEAD holds until i_Start.
//
// Ports
//   i_Clk, i_Rst_n    clock, asynchronous active-low reset
//   i_FrameTick       one-cycle pulse per video frame
//   i_Start           one-cycle pulse that (re)starts the enemy; beats every other event
//   i_Hit             one-cycle pulse on projectile collision (acted on only in ALIVE)
//   i_NextPosition    move-stage result {X[9:0], Y[8:0]}
//   o_EnemyState      1 = ALIVE
//   o_EnemyPosition   registered position, NONE when there is no enemy
//   o_PhaseState      00/11 = move left, 01/10 = move right
//   o_Dying           high while in DYING
//   o_StepStrobe      one-cycle pulse on each movement step
//   o_Destroyed       one-cycle pulse on entry to DYING
//
// States
//   state   | meaning
//   IDLE    | no enemy yet; waits for i_Start, frame ticks ignored
//   ALIVE   | moving one step every STEP_TICKS frame ticks
//   DYING   | explosion shown for DYING_TICKS frame ticks, position frozen
//   DEAD    | off-screen; waits for i_Start (or a respawn when enabled)

module first_row_enemy_ctrl #(
    parameter logic [18:0] NONE              = {19{1'b1}},
    parameter logic [8:0]  VERTICAL_POSITION = 9'd48,
    parameter logic [9:0]  INIT_X            = 10'd320,
    parameter logic [9:0]  X_MIN             = 10'd16,
    parameter logic [9:0]  X_MAX             = 10'd608,
    parameter int          STEP_TICKS        = 4,
    parameter int          PHASE_STEPS       = 32,
    parameter int          DYING_TICKS       = 8,
    parameter int          RESPAWN_TICKS     = 60
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_FrameTick,
    input  logic        i_Start,
    input  logic        i_Hit,
    input  logic [18:0] i_NextPosition,
    output logic        o_EnemyState,
    output logic [18:0] o_EnemyPosition,
    output logic [1:0]  o_PhaseState,
    output logic        o_Dying,
    output logic        o_StepStrobe,
    output logic        o_Destroyed
);

    localparam int FW = (STEP_TICKS  > 1) ? $clog2(STEP_TICKS)  : 1;
    localparam int SW = (PHASE_STEPS > 1) ? $clog2(PHASE_STEPS) : 1;
    localparam int DW = (DYING_TICKS > 1) ? $clog2(DYING_TICKS) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(STEP_TICKS - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(PHASE_STEPS - 1);
    localparam logic [DW-1:0] DYING_LAST = DW'(DYING_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIVE = 2'd1,
        S_DYING = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t          r_state;
    logic [FW-1:0]   r_frame_cnt;
    logic [SW-1:0]   r_step_cnt;
    logic [DW-1:0]   r_dying_cnt;

`ifdef FIRST_ROW_ENEMY_RESPAWN_EN
    localparam int RW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [RW-1:0] RESPAWN_LAST = RW'(RESPAWN_TICKS - 1);
    logic [RW-1:0]   r_respawn_cnt;
`else
    // Respawn timing is meaningless without the respawn counter.
    logic w_unused_respawn;
    assign w_unused_respawn = ^RESPAWN_TICKS;
`endif

    logic [9:0] w_next_x;
    logic [9:0] w_clamped_x;
    logic       w_next_valid;

    assign w_next_x     = i_NextPosition[18:9];
    assign w_next_valid = (i_NextPosition != NONE);
    assign w_clamped_x  = (w_next_x < X_MIN) ? X_MIN :
                          (w_next_x > X_MAX) ? X_MAX : w_next_x;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state         <= S_IDLE;
            r_frame_cnt     <= '0;
            r_step_cnt      <= '0;
            r_dying_cnt     <= '0;
`ifdef FIRST_ROW_ENEMY_RESPAWN_EN
            r_respawn_cnt   <= '0;
`endif
            o_EnemyState    <= 1'b0;
            o_EnemyPosition <= NONE;
            o_PhaseState    <= 2'b00;
            o_Dying         <= 1'b0;
            o_StepStrobe    <= 1'b0;
            o_Destroyed     <= 1'b0;
        end else begin
            o_StepStrobe <= 1'b0;
            o_Destroyed  <= 1'b0;

            if (i_Start) begin
                r_state         <= S_ALIVE;
                r_frame_cnt     <= '0;
                r_step_cnt      <= '0;
                r_dying_cnt     <= '0;
`ifdef FIRST_ROW_ENEMY_RESPAWN_EN
                r_respawn_cnt   <= '0;
`endif
                o_EnemyState    <= 1'b1;
                o_EnemyPosition <= {INIT_X, VERTICAL_POSITION};
                o_PhaseState    <= 2'b00;
                o_Dying         <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end

                    S_ALIVE: begin
                        // A hit on the same cycle as a step suppresses the step.
                        if (i_Hit) begin
                            r_state      <= S_DYING;
                            r_dying_cnt  <= '0;
                            o_EnemyState <= 1'b0;
                            o_Dying      <= 1'b1;
                            o_Destroyed  <= 1'b1;
                        end else if (i_FrameTick) begin
                            if (r_frame_cnt == FRAME_LAST) begin
                                r_frame_cnt  <= '0;
                                o_StepStrobe <= 1'b1;
                                // An invalid move result holds position but still counts as a step.
                                if (w_next_valid) begin
                                    o_EnemyPosition <= {w_clamped_x, VERTICAL_POSITION};
                                end
                                if (r_step_cnt == STEP_LAST) begin
                                    r_step_cnt   <= '0;
                                    o_PhaseState <= o_PhaseState + 2'd1;
                                end else begin
                                    r_step_cnt <= r_step_cnt + 1'b1;
                                end
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 1'b1;
                            end
                        end
                    end

                    S_DYING: begin
                        if (i_FrameTick) begin
                            if (r_dying_cnt == DYING_LAST) begin
                                r_state         <= S_DEAD;
                                r_dying_cnt     <= '0;
                                o_Dying         <= 1'b0;
                                o_EnemyPosition <= NONE;
`ifdef FIRST_ROW_ENEMY_RESPAWN_EN
                                r_respawn_cnt   <= '0;
`endif
                            end else begin
                                r_dying_cnt <= r_dying_cnt + 1'b1;
                            end
                        end
                    end

                    S_DEAD: begin
`ifdef FIRST_ROW_ENEMY_RESPAWN_EN
                        if (i_FrameTick) begin
                            if (r_respawn_cnt == RESPAWN_LAST) begin
                                r_state         <= S_ALIVE;
                                r_respawn_cnt   <= '0;
                                r_frame_cnt     <= '0;
                                r_step_cnt      <= '0;
                                o_EnemyState    <= 1'b1;
                                o_EnemyPosition <= {INIT_X, VERTICAL_POSITION};
                                o_PhaseState    <= 2'b00;
                            end else begin
                                r_respawn_cnt <= r_respawn_cnt + 1'b1;
                            end
                        end
`endif
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_first_row_enemy_ctrl.sv
module tb_first_row_enemy_ctrl;

    localparam logic [18:0] NONE = {19{1'b1}};
    localparam logic [8:0]  VP   = 9'd48;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        start;
    logic        hit;
    logic        force_none;
    logic [18:0] next_pos;
    logic        st;
    logic [18:0] pos;
    logic [1:0]  ph;
    logic        dying;
    logic        strobe;
    logic        destroyed;

    logic        c_start;
    logic        c_hit;
    logic [18:0] c_next_pos;
    logic        c_st;
    logic [18:0] c_pos;
    logic [1:0]  c_ph;
    logic        c_dying;
    logic        c_strobe;
    logic        c_destroyed;

    int n_checks = 0;
    int n_errors = 0;

    first_row_enemy_ctrl dut (
        .i_Clk           (clk),
        .i_Rst_n         (rst_n),
        .i_FrameTick     (tick),
        .i_Start         (start),
        .i_Hit           (hit),
        .i_NextPosition  (next_pos),
        .o_EnemyState    (st),
        .o_EnemyPosition (pos),
        .o_PhaseState    (ph),
        .o_Dying         (dying),
        .o_StepStrobe    (strobe),
        .o_Destroyed     (destroyed)
    );

    first_row_enemy_ctrl #(.X_MIN(10'd300)) dut_clamp (
        .i_Clk           (clk),
        .i_Rst_n         (rst_n),
        .i_FrameTick     (tick),
        .i_Start         (c_start),
        .i_Hit           (c_hit),
        .i_NextPosition  (c_next_pos),
        .o_EnemyState    (c_st),
        .o_EnemyPosition (c_pos),
        .o_PhaseState    (c_ph),
        .o_Dying         (c_dying),
        .o_StepStrobe    (c_strobe),
        .o_Destroyed     (c_destroyed)
    );

    // Row-move stage model: one pixel left in phases 00/11, right in 01/10.
    function automatic logic [18:0] move_stage(input logic alive, input logic [18:0] p,
                                               input logic [1:0] phase);
        logic [9:0] x;
        if (!alive || p == NONE) return NONE;
        x = (phase == 2'b00 || phase == 2'b11) ? p[18:9] - 10'd1 : p[18:9] + 10'd1;
        return {x, p[8:0]};
    endfunction

    always_comb begin
        next_pos   = force_none ? NONE : move_stage(st, pos, ph);
        c_next_pos = move_stage(c_st, c_pos, c_ph);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic frame_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) frame_tick();
    endtask

    task automatic do_steps(input int n);
        ticks(4 * n);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (st !== 1'b0 || pos !== NONE || ph !== 2'b00 || dying !== 1'b0 ||
            strobe !== 1'b0 || destroyed !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: st=%b pos=%h ph=%b dying=%b strobe=%b destroyed=%b required 0 7ffff 00 0 0 0",
                     st, pos, ph, dying, strobe, destroyed);
        end
        ticks(5);
        n_checks++;
        if (st !== 1'b0 || pos !== NONE || strobe !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_ignores_tick: st=%b pos=%h strobe=%b required 0 7ffff 0", st, pos, strobe);
        end
    endtask

    task automatic test_start();
        pulse_start();
        n_checks++;
        if (st !== 1'b1 || pos !== {10'd320, VP} || ph !== 2'b00 || dying !== 1'b0) begin
            n_errors++;
            $display("FAIL start: st=%b pos=%h ph=%b dying=%b required 1 %h 00 0",
                     st, pos, ph, dying, {10'd320, VP});
        end
    endtask

    task automatic test_step();
        ticks(3);
        n_checks++;
        if (strobe !== 1'b0 || pos[18:9] !== 10'd320) begin
            n_errors++;
            $display("FAIL step_early: strobe=%b x=%0d required 0 320", strobe, pos[18:9]);
        end
        frame_tick();
        n_checks++;
        if (strobe !== 1'b1 || pos !== {10'd319, VP}) begin
            n_errors++;
            $display("FAIL first_step: strobe=%b x=%0d y=%0d required 1 319 48", strobe, pos[18:9], pos[8:0]);
        end
        @(negedge clk);
        n_checks++;
        if (strobe !== 1'b0) begin
            n_errors++;
            $display("FAIL strobe_width: strobe=%b required 0", strobe);
        end
        do_steps(30);
        n_checks++;
        if (pos[18:9] !== 10'd289 || ph !== 2'b00) begin
            n_errors++;
            $display("FAIL step31: x=%0d ph=%b required 289 00", pos[18:9], ph);
        end
        do_steps(1);
        n_checks++;
        if (pos[18:9] !== 10'd288 || ph !== 2'b01 || strobe !== 1'b1) begin
            n_errors++;
            $display("FAIL step32: x=%0d ph=%b strobe=%b required 288 01 1", pos[18:9], ph, strobe);
        end
    endtask

    task automatic test_full_cycle();
        do_steps(32);
        n_checks++;
        if (pos[18:9] !== 10'd320 || ph !== 2'b10) begin
            n_errors++;
            $display("FAIL phase01_end: x=%0d ph=%b required 320 10", pos[18:9], ph);
        end
        do_steps(32);
        n_checks++;
        if (pos[18:9] !== 10'd352 || ph !== 2'b11) begin
            n_errors++;
            $display("FAIL phase10_end: x=%0d ph=%b required 352 11", pos[18:9], ph);
        end
        do_steps(32);
        n_checks++;
        if (pos !== {10'd320, VP} || ph !== 2'b00) begin
            n_errors++;
            $display("FAIL full_cycle: x=%0d ph=%b required 320 00", pos[18:9], ph);
        end
    endtask

    task automatic test_none_hold();
        force_none = 1'b1;
        do_steps(1);
        force_none = 1'b0;
        n_checks++;
        if (pos !== {10'd320, VP} || strobe !== 1'b1) begin
            n_errors++;
            $display("FAIL none_hold: x=%0d strobe=%b required 320 1", pos[18:9], strobe);
        end
        do_steps(31);
        n_checks++;
        if (pos[18:9] !== 10'd289 || ph !== 2'b01) begin
            n_errors++;
            $display("FAIL none_counts: x=%0d ph=%b required 289 01", pos[18:9], ph);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        ticks(2);
        pulse_start();
        n_checks++;
        if (pos !== {10'd320, VP} || ph !== 2'b00 || st !== 1'b1) begin
            n_errors++;
            $display("FAIL restart: x=%0d ph=%b st=%b required 320 00 1", pos[18:9], ph, st);
        end
        ticks(3);
        n_checks++;
        if (strobe !== 1'b0 || pos[18:9] !== 10'd320) begin
            n_errors++;
            $display("FAIL restart_cnt_clear: strobe=%b x=%0d required 0 320", strobe, pos[18:9]);
        end
        frame_tick();
        n_checks++;
        if (strobe !== 1'b1 || pos[18:9] !== 10'd319) begin
            n_errors++;
            $display("FAIL restart_step: strobe=%b x=%0d required 1 319", strobe, pos[18:9]);
        end
    endtask

    task automatic test_hit();
        pulse_start();
        ticks(3);
        @(negedge clk) begin tick = 1'b1; hit = 1'b1; end
        @(negedge clk) begin tick = 1'b0; hit = 1'b0; end
        n_checks++;
        if (pos !== {10'd320, VP} || destroyed !== 1'b1 || dying !== 1'b1 ||
            st !== 1'b0 || strobe !== 1'b0) begin
            n_errors++;
            $display("FAIL hit_wins: x=%0d destroyed=%b dying=%b st=%b strobe=%b required 320 1 1 0 0",
                     pos[18:9], destroyed, dying, st, strobe);
        end
        @(negedge clk) hit = 1'b1;
        @(negedge clk) hit = 1'b0;
        n_checks++;
        if (destroyed !== 1'b0 || dying !== 1'b1) begin
            n_errors++;
            $display("FAIL hit_in_dying: destroyed=%b dying=%b required 0 1", destroyed, dying);
        end
        ticks(7);
        n_checks++;
        if (dying !== 1'b1 || pos !== {10'd320, VP}) begin
            n_errors++;
            $display("FAIL dying_7: dying=%b pos=%h required 1 %h", dying, pos, {10'd320, VP});
        end
        frame_tick();
        n_checks++;
        if (dying !== 1'b0 || pos !== NONE || st !== 1'b0) begin
            n_errors++;
            $display("FAIL dead_entry: dying=%b pos=%h st=%b required 0 7ffff 0", dying, pos, st);
        end
        @(negedge clk) hit = 1'b1;
        @(negedge clk) hit = 1'b0;
        n_checks++;
        if (destroyed !== 1'b0 || dying !== 1'b0 || st !== 1'b0) begin
            n_errors++;
            $display("FAIL hit_in_dead: destroyed=%b dying=%b st=%b required 0 0 0", destroyed, dying, st);
        end
`ifdef FIRST_ROW_ENEMY_RESPAWN_EN
        ticks(59);
        n_checks++;
        if (st !== 1'b0 || pos !== NONE) begin
            n_errors++;
            $display("FAIL respawn_early: st=%b pos=%h required 0 7ffff", st, pos);
        end
        frame_tick();
        n_checks++;
        if (st !== 1'b1 || pos !== {10'd320, VP} || ph !== 2'b00) begin
            n_errors++;
            $display("FAIL respawn: st=%b x=%0d ph=%b required 1 320 00", st, pos[18:9], ph);
        end
`else
        ticks(200);
        n_checks++;
        if (st !== 1'b0 || pos !== NONE || ph !== 2'b00) begin
            n_errors++;
            $display("FAIL dead_sticky: st=%b pos=%h ph=%b required 0 7ffff 00", st, pos, ph);
        end
`endif
    endtask

    task automatic test_start_in_dying();
        pulse_start();
        @(negedge clk) hit = 1'b1;
        @(negedge clk) hit = 1'b0;
        n_checks++;
        if (dying !== 1'b1) begin
            n_errors++;
            $display("FAIL dying_before_restart: dying=%b required 1", dying);
        end
        pulse_start();
        n_checks++;
        if (st !== 1'b1 || dying !== 1'b0 || pos !== {10'd320, VP} || ph !== 2'b00) begin
            n_errors++;
            $display("FAIL start_in_dying: st=%b dying=%b x=%0d ph=%b required 1 0 320 00",
                     st, dying, pos[18:9], ph);
        end
    endtask

    task automatic test_clamp();
        @(negedge clk) c_start = 1'b1;
        @(negedge clk) c_start = 1'b0;
        do_steps(20);
        n_checks++;
        if (c_pos !== {10'd300, VP} || c_strobe !== 1'b1) begin
            n_errors++;
            $display("FAIL clamp_min: x=%0d strobe=%b required 300 1", c_pos[18:9], c_strobe);
        end
        do_steps(11);
        n_checks++;
        if (c_pos[18:9] !== 10'd300 || c_ph !== 2'b00) begin
            n_errors++;
            $display("FAIL clamp_hold: x=%0d ph=%b required 300 00", c_pos[18:9], c_ph);
        end
        do_steps(1);
        n_checks++;
        if (c_pos[18:9] !== 10'd300 || c_ph !== 2'b01) begin
            n_errors++;
            $display("FAIL clamp_phase: x=%0d ph=%b required 300 01", c_pos[18:9], c_ph);
        end
        do_steps(1);
        n_checks++;
        if (c_pos[18:9] !== 10'd301) begin
            n_errors++;
            $display("FAIL clamp_release: x=%0d required 301", c_pos[18:9]);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        tick       = 1'b0;
        start      = 1'b0;
        hit        = 1'b0;
        force_none = 1'b0;
        c_start    = 1'b0;
        c_hit      = 1'b0;
        test_reset();
        test_start();
        test_step();
        test_full_cycle();
        test_none_hold();
        test_back_to_back();
        test_hit();
        test_start_in_dying();
        test_clamp();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
